// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
// The bulk-clear sequencer uses a 2-bit state encoding.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks ptr over every index, one register per cycle,
// then emits a single-cycle done pulse. Busy/done decode straight off the state flop.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_nxt = ptr + AW'(1);
        if (ptr == LAST_IDX) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign clear_busy = (state == ST_CLEAR);
  assign clear_done = (state == ST_DONE);
  assign clr_en     = clear_busy;
  assign clr_idx    = ptr;

endmodule

// File: rtl/regfile_param.sv
// Decode-stage register file: one write port, NREAD combinational read ports,
// optional hardwired-zero top register, optional write-to-read bypass, bulk clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [DEPTH*WIDTH-1:0] reg_out,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  regfile_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx)
  );

  // Writes are dropped while clearing and never land in the zero register.
  assign wr_ok = wr_en && !clear_busy && !(ZERO_REG && (wr_addr == ZERO_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_dbg
    if (ZERO_REG && (i == DEPTH - 1)) begin : g_zero
      assign reg_out[i*WIDTH +: WIDTH] = '0;
    end else begin : g_mem
      assign reg_out[i*WIDTH +: WIDTH] = mem[i];
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      data = mem[addr];
      if (BYPASS && wr_ok && (wr_addr == addr)) data = wr_data;
      if (ZERO_REG && (addr == ZERO_IDX)) data = '0;
    end

    assign rd_data[k*WIDTH +: WIDTH] = data;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench: a default-config instance (zero reg + bypass)
// and a small 32x8, 3-port instance without zero reg or bypass, checked against array models.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: WIDTH 64, DEPTH 32, NREAD 2, ZERO_REG 1, BYPASS 1
  logic          wr_en0, clear_req0, busy0, done0;
  logic [4:0]    wr_addr0;
  logic [63:0]   wr_data0;
  logic [9:0]    rd_addr0;
  logic [127:0]  rd_data0;
  logic [2047:0] reg_out0;

  // instance 1: WIDTH 32, DEPTH 8, NREAD 3, ZERO_REG 0, BYPASS 0
  logic          wr_en1, clear_req1, busy1, done1;
  logic [2:0]    wr_addr1;
  logic [31:0]   wr_data1;
  logic [8:0]    rd_addr1;
  logic [95:0]   rd_data1;
  logic [255:0]  reg_out1;

  regfile_param dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .reg_out(reg_out0),
    .clear_req(clear_req0), .clear_busy(busy0), .clear_done(done0)
  );

  regfile_param #(.WIDTH(32), .DEPTH(8), .NREAD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .reg_out(reg_out1),
    .clear_req(clear_req1), .clear_busy(busy1), .clear_done(done1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m0 [32];
  logic [31:0] m1 [8];

  function automatic logic [2047:0] pack0();
    logic [2047:0] p;
    for (int i = 0; i < 32; i++) p[i*64 +: 64] = m0[i];
    return p;
  endfunction

  function automatic logic [255:0] pack1();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = m1[i];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0; rd_addr0 = '0; clear_req0 = 1'b0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; rd_addr1 = '0; clear_req1 = 1'b0;
  endtask

  task automatic models_zero();
    for (int i = 0; i < 32; i++) m0[i] = '0;
    for (int i = 0; i < 8; i++) m1[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    models_zero();
    #3;
    n_cmp++;
    if (reg_out0 !== '0) begin
      n_bad++; $display("FAIL reset_regs0: got %h required 0", reg_out0[255:0]);
    end
    n_cmp++;
    if (reg_out1 !== '0) begin
      n_bad++; $display("FAIL reset_regs1: got %h required 0", reg_out1);
    end
    n_cmp++;
    if ({busy0, done0, busy1, done1} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b required 0000", {busy0, done0, busy1, done1});
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'hDEADBEEF_CAFEF00D;
    step();
    m0[5] = 64'hDEADBEEF_CAFEF00D;
    wr_en0 = 1'b0;
    rd_addr0 = {5'd6, 5'd5};
    #1;
    n_cmp++;
    if (rd_data0[63:0] !== 64'hDEADBEEF_CAFEF00D) begin
      n_bad++; $display("FAIL wr_rd_port0: got %h required deadbeefcafef00d", rd_data0[63:0]);
    end
    n_cmp++;
    if (rd_data0[127:64] !== 64'd0) begin
      n_bad++; $display("FAIL wr_rd_port1: got %h required 0", rd_data0[127:64]);
    end
    n_cmp++;
    if (reg_out0 !== pack0()) begin
      n_bad++; $display("FAIL wr_regout0: low got %h", reg_out0[511:0]);
    end
  endtask

  task automatic test_zero_reg();
    wr_en0 = 1'b1; wr_addr0 = 5'd31; wr_data0 = 64'h1234;
    rd_addr0 = {5'd31, 5'd31};
    #1;
    n_cmp++;
    if (rd_data0 !== 128'd0) begin
      n_bad++; $display("FAIL zero_bypass: got %h required 0", rd_data0);
    end
    step();
    wr_en0 = 1'b0;
    #1;
    n_cmp++;
    if (reg_out0[31*64 +: 64] !== 64'd0) begin
      n_bad++; $display("FAIL zero_regout: got %h required 0", reg_out0[31*64 +: 64]);
    end
    n_cmp++;
    if (rd_data0 !== 128'd0) begin
      n_bad++; $display("FAIL zero_read: got %h required 0", rd_data0);
    end
    // without a zero register the top index is an ordinary register
    wr_en1 = 1'b1; wr_addr1 = 3'd7; wr_data1 = 32'h0BAD_F00D;
    step();
    wr_en1 = 1'b0;
    m1[7] = 32'h0BAD_F00D;
    n_cmp++;
    if (reg_out1 !== pack1()) begin
      n_bad++; $display("FAIL top_writable1: got %h required %h", reg_out1, pack1());
    end
  endtask

  task automatic test_bypass();
    wr_en1 = 1'b1; wr_addr1 = 3'd7; wr_data1 = 32'h55;
    step();
    m1[7] = 32'h55;
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'hAA; rd_addr0 = {5'd7, 5'd7};
    wr_en1 = 1'b1; wr_addr1 = 3'd7; wr_data1 = 32'hAA; rd_addr1 = {3'd7, 3'd7, 3'd7};
    #1;
    n_cmp++;
    if (rd_data0 !== {64'hAA, 64'hAA}) begin
      n_bad++; $display("FAIL bypass_on: got %h required both aa", rd_data0);
    end
    n_cmp++;
    if (rd_data1 !== {32'h55, 32'h55, 32'h55}) begin
      n_bad++; $display("FAIL bypass_off: got %h required all 55", rd_data1);
    end
    step();
    m0[7] = 64'hAA;
    m1[7] = 32'hAA;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    n_cmp++;
    if (reg_out0 !== pack0() || reg_out1 !== pack1()) begin
      n_bad++; $display("FAIL bypass_commit: got %h / %h", reg_out0[511:448], reg_out1[255:224]);
    end
  endtask

  task automatic test_random();
    logic [4:0]  a0;
    logic [2:0]  a1;
    logic [63:0] e0;
    for (int it = 0; it < 80; it++) begin
      wr_en0   = 1'($urandom_range(0, 1));
      wr_addr0 = 5'($urandom_range(0, 31));
      wr_data0 = {$urandom, $urandom};
      for (int k = 0; k < 2; k++) rd_addr0[k*5 +: 5] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) rd_addr0[4:0] = wr_addr0;
      wr_en1   = 1'($urandom_range(0, 1));
      wr_addr1 = 3'($urandom_range(0, 7));
      wr_data1 = $urandom;
      for (int k = 0; k < 3; k++) rd_addr1[k*3 +: 3] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rd_addr1[5:3] = wr_addr1;
      #1;
      for (int k = 0; k < 2; k++) begin
        a0 = rd_addr0[k*5 +: 5];
        if (a0 == 5'd31) e0 = 64'd0;
        else if (wr_en0 && a0 == wr_addr0) e0 = wr_data0;
        else e0 = m0[a0];
        n_cmp++;
        if (rd_data0[k*64 +: 64] !== e0) begin
          n_bad++; $display("FAIL rand_rd0 it%0d port%0d: got %h required %h", it, k, rd_data0[k*64 +: 64], e0);
        end
      end
      for (int k = 0; k < 3; k++) begin
        a1 = rd_addr1[k*3 +: 3];
        n_cmp++;
        if (rd_data1[k*32 +: 32] !== m1[a1]) begin
          n_bad++; $display("FAIL rand_rd1 it%0d port%0d: got %h required %h", it, k, rd_data1[k*32 +: 32], m1[a1]);
        end
      end
      step();
      if (wr_en0 && wr_addr0 != 5'd31) m0[wr_addr0] = wr_data0;
      if (wr_en1) m1[wr_addr1] = wr_data1;
      n_cmp++;
      if (reg_out0 !== pack0() || reg_out1 !== pack1()) begin
        n_bad++; $display("FAIL rand_regout it%0d: got %h required %h", it, reg_out1, pack1());
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    logic eb0, ed0, eb1, ed1;
    for (int i = 0; i < 31; i++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = 64'(i + 1);
      step();
      m0[i] = 64'(i + 1);
    end
    wr_en0 = 1'b0;
    n_cmp++;
    if (reg_out0 !== pack0()) begin
      n_bad++; $display("FAIL clr_fill: got %h", reg_out0[511:0]);
    end
    clear_req0 = 1'b1; clear_req1 = 1'b1;
    step();
    clear_req0 = 1'b0;
    // n counts edges since clear_req was sampled; dut1 keeps its request up to restart once
    for (int n = 0; n <= 34; n++) begin
      eb0 = (n < 32);
      ed0 = (n == 32);
      eb1 = (n < 8) || (n >= 10 && n < 18);
      ed1 = (n == 8) || (n == 18);
      if (n == 10) clear_req1 = 1'b0;
      n_cmp++;
      if ({busy0, done0} !== {eb0, ed0}) begin
        n_bad++; $display("FAIL clr_flags0 n%0d: got %b%b required %b%b", n, busy0, done0, eb0, ed0);
      end
      n_cmp++;
      if ({busy1, done1} !== {eb1, ed1}) begin
        n_bad++; $display("FAIL clr_flags1 n%0d: got %b%b required %b%b", n, busy1, done1, eb1, ed1);
      end
      if (n == 5) begin
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'h5555; rd_addr0 = {5'd20, 5'd3};
        #1;
        n_cmp++;
        if (rd_data0 !== {64'd21, 64'd0}) begin
          n_bad++; $display("FAIL clr_midread: got %h required %h", rd_data0, {64'd21, 64'd0});
        end
      end else begin
        wr_en0 = 1'b0;
      end
      step();
    end
    models_zero();
    n_cmp++;
    if (reg_out0 !== '0 || reg_out1 !== '0) begin
      n_bad++; $display("FAIL clr_result: got %h / %h required 0", reg_out0[511:0], reg_out1);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < 6; i++) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(i * 4); wr_data0 = {$urandom, $urandom} | 64'd1;
      step();
    end
    wr_en0 = 1'b0;
    clear_req0 = 1'b1;
    step();
    clear_req0 = 1'b0;
    for (int n = 0; n < 10; n++) step();
    rst = 1'b1;
    #1;
    models_zero();
    n_cmp++;
    if ({busy0, done0} !== 2'b00) begin
      n_bad++; $display("FAIL rstclr_flags: got %b%b required 00", busy0, done0);
    end
    n_cmp++;
    if (reg_out0 !== '0 || reg_out1 !== '0) begin
      n_bad++; $display("FAIL rstclr_regs: got %h required 0", reg_out0[1023:0]);
    end
    step();
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      n_cmp++;
      if ({busy0, done0} !== 2'b00) begin
        n_bad++; $display("FAIL rstclr_idle n%0d: got %b%b required 00", n, busy0, done0);
      end
    end
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en0 = 1'b0;
    m0[9] = 64'h0123_4567_89AB_CDEF;
    n_cmp++;
    if (reg_out0 !== pack0()) begin
      n_bad++; $display("FAIL rstclr_write: got %h required %h", reg_out0[9*64 +: 64], m0[9]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file: the next-generation CPU register file, with configurable width, depth and read-port count. Adds an optional hardwired-zero top register, optional same-cycle write-to-read bypass, and a sequenced bulk-clear engine with a busy/done handshake. Sits in the decode stage; read ports feed the operand path and the writeback stage drives the write port.

## Interface
Parameters:
- WIDTH, 64, bits per register
- DEPTH, 32, number of registers; power of two, ≥ 2
- NREAD, 2, number of read ports, 1..4
- ZERO_REG, 1, when 1, register DEPTH-1 is hardwired to zero
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads

Ports (AW = $clog2(DEPTH)):
- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, asynchronous, active-high reset
- wr_en, in, 1, write strobe
- wr_addr, in, AW, write index
- wr_data, in, WIDTH, write value
- rd_addr, in, NREAD×AW, packed read indices; port k uses slice k
- rd_data, out, NREAD×WIDTH, packed read data; combinational
- reg_out, out, DEPTH×WIDTH, all register contents, for debug and testbench
- clear_req, in, 1, bulk-clear request; level-sampled while the engine is IDLE
- clear_busy, out, 1, high while a clear is in progress
- clear_done, out, 1, one-cycle pulse when a clear completes

## Operation
- **Reset:**
  - While rst is high, all registers are 0.
  - FSM is in IDLE; clear_busy = 0 and clear_done = 0.
  - Asserting rst mid-clear aborts the clear immediately. No done pulse is produced.
- **Write:**
  - At a clock edge with wr_en = 1 and clear_busy = 0, wr_data is stored to wr_addr.
  - The write is ignored if ZERO_REG = 1 and wr_addr = DEPTH-1.
  - A write with clear_busy = 1 is dropped silently.
- **Read:**
  - rd_data[k] = reg[rd_addr[k]], combinational.
  - If ZERO_REG = 1 and the address is DEPTH-1, the result is 0 regardless of anything else.
  - If BYPASS = 1, wr_en = 1, clear_busy = 0 and wr_addr matches (and is not the zero register), rd_data[k] = wr_data.
  - Every port is evaluated independently. Duplicate addresses are legal.
- **Clear FSM** (states IDLE, CLEAR, DONE):
  - IDLE: clear_req = 1 → CLEAR, with ptr = 0.
  - CLEAR: at each edge, reg[ptr] is set to 0 and ptr increments. After ptr = DEPTH-1 has been written, go to DONE. clear_busy = 1 throughout.
  - DONE: clear_done = 1 for exactly one cycle, then → IDLE. clear_busy = 0.
  - clear_req is ignored in CLEAR and DONE. If it is still high in IDLE after DONE, a new clear starts.
  - During CLEAR, reads return 0 for indices below ptr and old contents for the rest. There is no read stall.

## Timing
- Read latency is 0 cycles (combinational from rd_addr and from the bypass inputs).
- Write latency is 1 edge: the value is visible in reg_out after the edge.
- Clear takes DEPTH cycles in CLEAR plus 1 in DONE. clear_busy rises on the edge after clear_req is sampled in IDLE.
- Total time from clear_req to the clear_done pulse is DEPTH+1 edges.
- clear_busy and clear_done are registered outputs with no combinational path from clear_req.
- A write in the same cycle that clear_req is sampled in IDLE is performed; that register is then zeroed by the clear.

## Structure
- Package regfile_pkg holds:
  - the clear FSM state enum (2-bit encoding);
  - default parameter constants (REGFILE_WIDTH = 64, REGFILE_DEPTH = 32).
- Sub-module regfile_clear_fsm: owns the state register, ptr counter, clear_busy and clear_done. It outputs clr_en and clr_idx to the storage array.
- Storage, write decode and read muxing stay in the top module. Read ports come from a generate loop over NREAD.

## Test plan
- **Reset, write and read:** after reset, every reg_out is 0. Write 0xDEADBEEF_CAFEF00D to index 5, then read port 0 at 5 → returns that value; port 1 at 6 → 0.
- **Zero register:** write 0x1234 to index 31 (ZERO_REG = 1) → reg_out[31] stays 0, and a read of 31 returns 0. Repeat with bypass active; still 0.
- **Bypass:** in the same cycle, wr_en = 1, wr_addr = 7, wr_data = 0xAA, and both rd_addr = 7 → both rd_data = 0xAA before the edge. With BYPASS = 0, both return the old value.
- **Bulk clear:** fill all 31 registers with index+1 and pulse clear_req.
  - clear_busy is high for exactly 32 cycles; clear_done pulses on cycle 33.
  - All registers are then 0.
  - A wr_en to index 3 mid-clear is dropped.
- **Reset mid-clear:** assert rst at clear cycle 10 → clear_busy = 0 immediately, no done pulse, all registers 0, FSM in IDLE.
- **Parameter sweep:** WIDTH = 32, DEPTH = 8, NREAD = 3, ZERO_REG = 0 → index 7 is writable, three independent reads are correct, and a clear takes 8 + 1 cycles.
